// File: rtl/display_sched_pkg.sv
// -----------------------------------------------------------------------------
// display_sched_pkg
// Shared definitions for the display scheduler:
//   state_e   : scheduler FSM state encoding (IDLE, GAP, SHOW)
//   SRC_*     : source indices (0 = background floor word, 3 = alarm)
//   NUM_SRC   : number of display sources
//   src_word  : extracts the 16-bit word of one source from the packed
//               64-bit req_data bus (source i at bits [16*i+15:16*i])
// -----------------------------------------------------------------------------
package display_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GAP  = 2'd1,
      ST_SHOW = 2'd2
   } state_e;

   localparam logic [1:0] SRC_FLOOR = 2'd0;
   localparam logic [1:0] SRC_ALARM = 2'd3;
   localparam int         NUM_SRC   = 4;

   function automatic logic [15:0] src_word(input logic [63:0] data,
                                            input logic [1:0]  idx);
      return data[{idx, 4'b0000} +: 16];
   endfunction

endpackage

// File: rtl/ms_timer.sv
// -----------------------------------------------------------------------------
// ms_timer
// Loadable down-counter, one tick per display clock cycle (1 ms).
// Ports:
//   clk_i      : display clock
//   rst_i      : synchronous active-high reset (count -> 0)
//   load_i     : load load_val_i this cycle (wins over counting)
//   load_val_i : interval length in cycles
//   done_o     : high during the last cycle of the interval and while the
//                count rests at 0 afterwards
// Loading N gives exactly N cycles before the cycle in which done_o is first
// seen by the consumer's clock edge; the count never wraps below 0.
// -----------------------------------------------------------------------------
module ms_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The edge that sees count 1 is the N-th edge after the load.
   assign done_o = (cnt_q <= W'(1));

endmodule

// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
// Time-shares the 4-digit seven-segment display between four sources:
// source 0 background floor word, sources 1/2 transient messages, source 3
// urgent alarm. Inserts a blank gap before every newly granted message,
// holds each message for a minimum dwell, blinks the alarm.
// Ports:
//   clk_1kHz   : display clock (1 cycle = 1 ms)
//   rst        : synchronous active-high reset
//   req        : per-source request, req[0] ignored
//   req_data   : source i word at bits [16*i+15:16*i]
//   ack        : one-cycle pulse to source i when its dwell completes
//   grant      : one-hot currently displayed source
//   disp_word  : word for the seven-segment driver A input
//   disp_blank : 1 = force all digit anodes off
//   busy       : 1 when not IDLE
//   dbg_state  : current FSM state
// All outputs are registered; disp_word follows the granted source's live
// data with one cycle of latency.
//
// Request/acknowledge handshake: a source raises req[i] and holds it until
// it sees ack[i]; it drops req[i] in the cycle after the ack, so req[i] is
// still high at the first edge after ack and is ignored there (masked by the
// registered ack). A req[i] still high at the second edge after ack is a new
// request.
// -----------------------------------------------------------------------------
module display_scheduler
   import display_sched_pkg::*;
#(
   parameter int DWELL_MS = 2000,
   parameter int GAP_MS   = 100,
   parameter int BLINK_MS = 250
) (
   input  logic                   clk_1kHz,
   input  logic                   rst,
   input  logic [NUM_SRC-1:0]     req,
   input  logic [16*NUM_SRC-1:0]  req_data,
   output logic [NUM_SRC-1:0]     ack,
   output logic [NUM_SRC-1:0]     grant,
   output logic [15:0]            disp_word,
   output logic                   disp_blank,
   output logic                   busy,
   output state_e                 dbg_state
);

   localparam int TMAX_A = (DWELL_MS > GAP_MS) ? DWELL_MS : GAP_MS;
   localparam int TMAX   = (TMAX_A > BLINK_MS) ? TMAX_A : BLINK_MS;
   localparam int TW     = $clog2(TMAX + 1);

   localparam logic [TW-1:0] DWELL_V = TW'(DWELL_MS);
   localparam logic [TW-1:0] GAP_V   = TW'(GAP_MS);
   localparam logic [TW-1:0] BLINK_V = TW'(BLINK_MS);

   // First pending message source in round-robin order starting at ptr.
   function automatic logic [1:0] pick_rr(input logic [3:0] r,
                                          input logic [1:0] ptr);
      if (ptr == 2'd2) begin
         return r[2] ? 2'd2 : 2'd1;
      end
      return r[1] ? 2'd1 : 2'd2;
   endfunction

   function automatic logic [1:0] other_src(input logic [1:0] t);
      return (t == 2'd1) ? 2'd2 : 2'd1;
   endfunction

   state_e       state_q, state_d;
   logic [1:0]   tgt_q, tgt_d;
   logic [1:0]   rr_q, rr_d;
   logic         blank_q, blank_d;
   logic [3:0]   ack_q, ack_d;
   logic         met_q, met_d;       // alarm dwell already acknowledged
   logic [3:0]   grant_q;
   logic [15:0]  word_q;
   logic         busy_q;

   logic         go_gap, go_idle;
   logic [1:0]   gap_tgt;
   logic         tmr_load, tmr_done;
   logic [TW-1:0] tmr_val;
   logic         blk_load, blk_done;
   logic [3:0]   eff_req;

   // Stale request from a just-acknowledged source is not a new request.
   assign eff_req = req & ~ack_q;

   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      rr_d     = rr_q;
      blank_d  = blank_q;
      ack_d    = '0;
      met_d    = met_q;
      go_gap   = 1'b0;
      go_idle  = 1'b0;
      gap_tgt  = tgt_q;
      tmr_load = 1'b0;
      tmr_val  = DWELL_V;
      blk_load = 1'b0;

      case (state_q)
         ST_IDLE: begin
            tgt_d   = SRC_FLOOR;
            blank_d = 1'b0;
            if (eff_req[SRC_ALARM]) begin
               go_gap  = 1'b1;
               gap_tgt = SRC_ALARM;
            end else if (eff_req[1] || eff_req[2]) begin
               go_gap  = 1'b1;
               gap_tgt = pick_rr(eff_req, rr_q);
            end
         end

         ST_GAP: begin
            if (tgt_q != SRC_ALARM && !req[tgt_q]) begin
               go_idle = 1'b1;
            end else if (tgt_q != SRC_ALARM && eff_req[SRC_ALARM]) begin
               // Retarget to the alarm; the gap restarts from full length.
               go_gap  = 1'b1;
               gap_tgt = SRC_ALARM;
            end else if (tmr_done) begin
               state_d  = ST_SHOW;
               tmr_load = 1'b1;
               tmr_val  = DWELL_V;
               blank_d  = 1'b0;
               met_d    = 1'b0;
               blk_load = 1'b1;
            end
         end

         ST_SHOW: begin
            if (tgt_q == SRC_ALARM) begin
               if (blk_done) begin
                  blank_d  = ~blank_q;
                  blk_load = 1'b1;
               end
               // Dwell timer rests at 0 after expiry, so met_q limits the
               // acknowledge to a single pulse while the alarm is held.
               if (tmr_done && !met_q) begin
                  ack_d[SRC_ALARM] = 1'b1;
                  met_d            = 1'b1;
               end
               if (tmr_done && !req[SRC_ALARM]) begin
                  if (eff_req[1] || eff_req[2]) begin
                     go_gap  = 1'b1;
                     gap_tgt = pick_rr(eff_req, rr_q);
                  end else begin
                     go_idle = 1'b1;
                  end
               end
            end else if (!req[tgt_q]) begin
               go_idle = 1'b1;
            end else if (tmr_done) begin
               ack_d[tgt_q] = 1'b1;
               rr_d         = other_src(tgt_q);
               if (eff_req[SRC_ALARM]) begin
                  go_gap  = 1'b1;
                  gap_tgt = SRC_ALARM;
               end else if (eff_req[other_src(tgt_q)]) begin
                  go_gap  = 1'b1;
                  gap_tgt = other_src(tgt_q);
               end else begin
                  go_idle = 1'b1;
               end
            end else if (eff_req[SRC_ALARM]) begin
               // Preemption: no ack and rr_ptr untouched, so the preempted
               // source is the next one served.
               go_gap  = 1'b1;
               gap_tgt = SRC_ALARM;
            end
         end

         default: begin
            go_idle = 1'b1;
         end
      endcase

      // Transition side effects applied last so they override blink updates.
      if (go_gap) begin
         state_d  = ST_GAP;
         tgt_d    = gap_tgt;
         tmr_load = 1'b1;
         tmr_val  = GAP_V;
         blank_d  = 1'b1;
      end else if (go_idle) begin
         state_d = ST_IDLE;
         tgt_d   = SRC_FLOOR;
         blank_d = 1'b0;
      end
   end

   always_ff @(posedge clk_1kHz) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tgt_q   <= SRC_FLOOR;
         rr_q    <= 2'd1;
         blank_q <= 1'b0;
         ack_q   <= '0;
         met_q   <= 1'b0;
         grant_q <= 4'b0001;
         word_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         rr_q    <= rr_d;
         blank_q <= blank_d;
         ack_q   <= ack_d;
         met_q   <= met_d;
         grant_q <= 4'b0001 << tgt_d;
         word_q  <= src_word(req_data, tgt_d);
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   ms_timer #(.W(TW)) u_dwell_tmr (
      .clk_i      (clk_1kHz),
      .rst_i      (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   ms_timer #(.W(TW)) u_blink_tmr (
      .clk_i      (clk_1kHz),
      .rst_i      (rst),
      .load_i     (blk_load),
      .load_val_i (BLINK_V),
      .done_o     (blk_done)
   );

   assign ack        = ack_q;
   assign grant      = grant_q;
   assign disp_word  = word_q;
   assign disp_blank = blank_q;
   assign busy       = busy_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_display_scheduler
// Cycle-by-cycle scoreboard for display_scheduler with DWELL_MS = 4,
// GAP_MS = 2, BLINK_MS = 2. Each driven cycle pushes the expected packed
// output {ack, grant, disp_word, disp_blank, busy} after the sampling edge;
// a negedge monitor pops and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_display_scheduler;
   import display_sched_pkg::*;

   localparam logic [15:0] D0  = 16'h0003;
   localparam logic [15:0] D0B = 16'h0007;
   localparam logic [15:0] D1  = 16'h0005;
   localparam logic [15:0] D2  = 16'h0022;
   localparam logic [15:0] D3  = 16'hEEEE;

   // ---------------- clock / reset ----------------
   logic        clk_1kHz = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] d0, d1, d2, d3;
   logic [63:0] req_data;
   logic [3:0]  ack, grant;
   logic [15:0] disp_word;
   logic        disp_blank, busy;
   state_e      dbg_state;

   assign req_data = {d3, d2, d1, d0};

   always #5 clk_1kHz = ~clk_1kHz;

   display_scheduler #(
      .DWELL_MS (4),
      .GAP_MS   (2),
      .BLINK_MS (2)
   ) dut (
      .clk_1kHz   (clk_1kHz),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .ack        (ack),
      .grant      (grant),
      .disp_word  (disp_word),
      .disp_blank (disp_blank),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [25:0] exp_q[$];
   string       tag_q[$];
   string       cur_tag;
   int          row_idx;
   int          check_cnt = 0;
   int          pass_cnt  = 0;
   logic [25:0] mon_exp;
   string       mon_tag;

   function automatic logic [25:0] row(input logic [3:0] a, input logic [3:0] g,
                                       input logic [15:0] w, input logic bl,
                                       input logic bz);
      return {a, g, w, bl, bz};
   endfunction

   task automatic check_eq(input string tag, input logic [25:0] got,
                           input logic [25:0] want);
      check_cnt++;
      if (got === want) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got ack=%b grant=%b word=%h blank=%b busy=%b, expected ack=%b grant=%b word=%h blank=%b busy=%b",
                  tag, got[25:22], got[21:18], got[17:2], got[1], got[0],
                  want[25:22], want[21:18], want[17:2], want[1], want[0]);
      end
   endtask

   always @(negedge clk_1kHz) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_tag = tag_q.pop_front();
         check_eq(mon_tag, {ack, grant, disp_word, disp_blank, busy}, mon_exp);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start(input string t);
      cur_tag = t;
      row_idx = 0;
   endtask

   task automatic tick(input logic r, input logic [3:0] q, input logic [25:0] e);
      rst = r;
      req = q;
      @(posedge clk_1kHz);
      exp_q.push_back(e);
      tag_q.push_back($sformatf("%s#%0d", cur_tag, row_idx));
      row_idx++;
      #1;
   endtask

   task automatic ticks(input int n, input logic r, input logic [3:0] q,
                        input logic [25:0] e);
      for (int i = 0; i < n; i++) begin
         tick(r, q, e);
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   logic [25:0] rst_r, idle0, gap1, show1, gap2, show2, gap3, sh3_on, sh3_off;

   initial begin
      rst_r   = row(4'b0000, 4'b0001, 16'h0000, 1'b0, 1'b0);
      idle0   = row(4'b0000, 4'b0001, D0, 1'b0, 1'b0);
      gap1    = row(4'b0000, 4'b0010, D1, 1'b1, 1'b1);
      show1   = row(4'b0000, 4'b0010, D1, 1'b0, 1'b1);
      gap2    = row(4'b0000, 4'b0100, D2, 1'b1, 1'b1);
      show2   = row(4'b0000, 4'b0100, D2, 1'b0, 1'b1);
      gap3    = row(4'b0000, 4'b1000, D3, 1'b1, 1'b1);
      sh3_on  = row(4'b0000, 4'b1000, D3, 1'b0, 1'b1);
      sh3_off = row(4'b0000, 4'b1000, D3, 1'b1, 1'b1);

      d0 = D0; d1 = D1; d2 = D2; d3 = D3;
      rst = 1'b1;
      req = 4'b0000;

      // Reset, then idle background tracking live source-0 data.
      start("reset");
      ticks(3, 1'b1, 4'b0000, rst_r);
      start("idle");
      tick(1'b0, 4'b0000, idle0);
      d0 = D0B;
      tick(1'b0, 4'b0000, row(4'b0000, 4'b0001, D0B, 1'b0, 1'b0));
      d0 = D0;
      tick(1'b0, 4'b0000, idle0);

      // Round-robin from rr_ptr = 1: source 1 then source 2.
      start("rr12");
      ticks(2, 1'b0, 4'b0110, gap1);
      ticks(4, 1'b0, 4'b0110, show1);
      tick(1'b0, 4'b0110, row(4'b0010, 4'b0100, D2, 1'b1, 1'b1));
      tick(1'b0, 4'b0110, gap2);
      ticks(4, 1'b0, 4'b0100, show2);
      tick(1'b0, 4'b0100, row(4'b0100, 4'b0001, D0, 1'b0, 1'b0));
      tick(1'b0, 4'b0100, idle0);
      tick(1'b0, 4'b0000, idle0);

      // Single message from source 1; stale req after ack is not re-granted.
      start("single");
      ticks(2, 1'b0, 4'b0010, gap1);
      ticks(4, 1'b0, 4'b0010, show1);
      tick(1'b0, 4'b0010, row(4'b0010, 4'b0001, D0, 1'b0, 1'b0));
      tick(1'b0, 4'b0010, idle0);
      tick(1'b0, 4'b0000, idle0);

      // Round-robin from rr_ptr = 2: source 2 then source 1.
      start("rr21");
      ticks(2, 1'b0, 4'b0110, gap2);
      ticks(4, 1'b0, 4'b0110, show2);
      tick(1'b0, 4'b0110, row(4'b0100, 4'b0010, D1, 1'b1, 1'b1));
      tick(1'b0, 4'b0110, gap1);
      ticks(4, 1'b0, 4'b0010, show1);
      tick(1'b0, 4'b0010, row(4'b0010, 4'b0001, D0, 1'b0, 1'b0));
      tick(1'b0, 4'b0010, idle0);
      tick(1'b0, 4'b0000, idle0);

      // Alarm preempts source 1 after two SHOW cycles; source 1 served after.
      start("preempt");
      ticks(2, 1'b0, 4'b0010, gap1);
      ticks(2, 1'b0, 4'b0010, show1);
      ticks(2, 1'b0, 4'b1010, gap3);
      ticks(2, 1'b0, 4'b1010, sh3_on);
      ticks(2, 1'b0, 4'b1010, sh3_off);
      tick(1'b0, 4'b1010, row(4'b1000, 4'b1000, D3, 1'b0, 1'b1));
      tick(1'b0, 4'b1010, sh3_on);
      ticks(2, 1'b0, 4'b0010, gap1);
      ticks(4, 1'b0, 4'b0010, show1);
      tick(1'b0, 4'b0010, row(4'b0010, 4'b0001, D0, 1'b0, 1'b0));
      tick(1'b0, 4'b0010, idle0);
      tick(1'b0, 4'b0000, idle0);

      // One-cycle alarm pulse still gets the full gap and dwell.
      start("alarm_pulse");
      tick(1'b0, 4'b1000, gap3);
      tick(1'b0, 4'b0000, gap3);
      ticks(2, 1'b0, 4'b0000, sh3_on);
      ticks(2, 1'b0, 4'b0000, sh3_off);
      tick(1'b0, 4'b0000, row(4'b1000, 4'b0001, D0, 1'b0, 1'b0));
      tick(1'b0, 4'b0000, idle0);

      // Source 2 withdraws in its second SHOW cycle: IDLE, no ack.
      start("withdraw");
      ticks(2, 1'b0, 4'b0100, gap2);
      ticks(2, 1'b0, 4'b0100, show2);
      ticks(2, 1'b0, 4'b0000, idle0);

      // Reset mid-GAP, then rr_ptr back at 1 picks source 1 first.
      start("reset_mid");
      tick(1'b0, 4'b0010, gap1);
      tick(1'b1, 4'b0010, rst_r);
      tick(1'b0, 4'b0000, idle0);
      ticks(2, 1'b0, 4'b0110, gap1);
      tick(1'b1, 4'b0000, rst_r);
      tick(1'b0, 4'b0000, idle0);

      // Let the monitor consume every expected row.
      @(posedge clk_1kHz);
      @(posedge clk_1kHz);
      #1;
      check_eq("scoreboard_drained", 26'(exp_q.size()), 26'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
